// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic             io_bin;
    logic [WIDTH-1:0] io_lhs;
    logic [WIDTH-1:0] io_rhs;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out;
    logic             io_bout;

    modport master (
        output io_in_valid,
        output io_bin,
        output io_lhs,
        output io_rhs,
        output io_out_ready,
        input  io_in_ready,
        input  io_out_valid,
        input  io_out,
        input  io_bout
    );

    modport slave (
        input  io_in_valid,
        input  io_bin,
        input  io_lhs,
        input  io_rhs,
        input  io_out_ready,
        output io_in_ready,
        output io_out_valid,
        output io_out,
        output io_bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor, one bit per clock
// IDLE accepts operands, BUSY runs WIDTH borrow-chain steps, DONE holds the result until taken.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             bout_q;

    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] d_next;

    // Difference bits enter at the MSB so that after WIDTH steps bit 0 sits at position 0.
    always_comb begin
        a0               = a_sh[0];
        b0               = b_sh[0];
        d                = a0 ^ b0 ^ br;
        br_next          = (~a0 & b0) | (~a0 & br) | (b0 & br);
        d_next           = d_sh >> 1;
        d_next[WIDTH-1]  = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            d_sh        <= '0;
            br          <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            bout_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.io_in_valid) begin
                        a_sh       <= bus.io_lhs;
                        b_sh       <= bus.io_rhs;
                        br         <= bus.io_bin;
                        d_sh       <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    d_sh <= d_next;
                    if (cnt == LAST) begin
                        out_valid_q <= 1'b1;
                        out_q       <= d_next;
                        bout_q      <= br_next;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Returning to IDLE takes this whole edge; in_ready only rises afterwards.
                    if (bus.io_out_ready) begin
                        out_valid_q <= 1'b0;
                        out_q       <= '0;
                        bout_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.io_in_ready  = in_ready_q;
    assign bus.io_out_valid = out_valid_q;
    assign bus.io_out       = out_q;
    assign bus.io_bout      = bout_q;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, operand/result width in bits; legal range 1..64.
REQ-002 Port SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port SHALL be: io_in_valid  input  1  operand set offered.
REQ-005 Port SHALL be: io_in_ready  output  1  block can accept operands.
REQ-006 Port SHALL be: io_bin  input  1  borrow-in.
REQ-007 Port SHALL be: io_lhs  input  WIDTH  minuend, unsigned.
REQ-008 Port SHALL be: io_rhs  input  WIDTH  subtrahend, unsigned.
REQ-009 Port SHALL be: io_out_valid  output  1  result available.
REQ-010 Port SHALL be: io_out_ready  input  1  consumer takes result.
REQ-011 Port SHALL be: io_out  output  WIDTH  difference.
REQ-012 Port SHALL be: io_bout  output  1  borrow-out.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE: io_in_ready=1, io_out_valid=0; on an edge with io_in_valid=1, the block SHALL capture io_lhs, io_rhs and io_bin, clear the bit counter, and go to BUSY.
REQ-015 Operands SHALL be sampled only at the accepting edge; later input changes SHALL be ignored until the next acceptance.
REQ-016 BUSY: io_in_ready=0, io_out_valid=0; each edge SHALL process exactly one bit, LSB first: d = a XOR b XOR br; br_next = (~a & b) | (~a & br) | (b & br).
REQ-017 The borrow chain SHALL start from the captured io_bin at bit 0.
REQ-018 After bit WIDTH-1 is processed, the block SHALL enter DONE, so io_out_valid rises exactly WIDTH edges after the accepting edge.
REQ-019 The bit counter SHALL be wide enough for WIDTH-1 with no wrap; for WIDTH=1, BUSY SHALL last exactly one edge.
REQ-020 DONE: io_out_valid=1 and io_in_ready=0.
REQ-021 In DONE, io_out SHALL equal (lhs - rhs - bin) mod 2^WIDTH, and io_bout SHALL be 1 iff lhs < rhs + bin (unsigned, full precision).
REQ-022 io_out and io_bout SHALL be held stable for the whole time io_out_valid=1.
REQ-023 DONE SHALL persist while io_out_ready=0 (backpressure, no timeout); on an edge with io_out_ready=1, the block SHALL return to IDLE.
REQ-024 Acceptance in the DONE-to-IDLE cycle SHALL NOT occur; the next operand set is accepted no earlier than one edge later.
REQ-025 Minimum initiation interval SHALL be WIDTH+2 cycles.
REQ-026 io_out and io_bout SHALL be driven 0 whenever io_out_valid=0.
REQ-027 io_in_valid in BUSY/DONE and io_out_ready in IDLE/BUSY SHALL have no effect.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE and clear operand, borrow, counter and result registers; after that edge io_in_ready=1, io_out_valid=0, io_out=0, io_bout=0.
REQ-029 reset SHALL take priority over all handshakes, including mid-BUSY and in DONE; a partial computation SHALL be discarded and never presented.
REQ-030 With reset and io_in_valid both high at the same edge, the operands SHALL NOT be accepted.

Verification (WIDTH=8)
REQ-031 lhs=0x05, rhs=0x03, bin=0, out_ready=1 -> out_valid after exactly 8 edges, io_out=0x02, io_bout=0.
REQ-032 lhs=0x00, rhs=0x01, bin=0 -> io_out=0xFF, io_bout=1; lhs=0x10, rhs=0x10, bin=1 -> io_out=0xFF, io_bout=1.
REQ-033 lhs=0xFF, rhs=0x00, bin=1 with out_ready held 0 for 5 cycles -> io_out=0xFE, io_bout=0 stable all 5 cycles; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-034 Accept lhs=0xA0, rhs=0x0B, then change io_lhs/io_rhs every cycle during BUSY -> io_out=0x95, io_bout=0.
REQ-035 Assert reset at the 4th BUSY edge -> next cycle in_ready=1, out_valid=0; following op lhs=0x01, rhs=0x02, bin=0 -> io_out=0xFF, io_bout=1 with no residue.
REQ-036 Random back-to-back ops with random out_ready stalls -> every result matches REQ-021; interval between acceptances >= 10 cycles.
